// File: rtl/comp_dsp_pkg.sv
// Shared definitions for the complex DSP datapath blocks: integer log2,
// accumulator sizing and the integrate-and-dump state encoding.
package comp_dsp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Enough headroom that a full window of extreme samples cannot overflow
    function automatic int acc_width(input int in_w, input int max_len);
        return in_w + clog2(max_len);
    endfunction

endpackage

// File: rtl/comp_integrate_dump_sat_shift.sv
// Arithmetic right shift of a wide signed value followed by either
// saturation or sign-preserving truncation to the output width.
module sat_shift #(
    parameter int IN_W          = 28,
    parameter int OUT_W         = 18,
    parameter int SHIFT         = 0,
    parameter int WRAP_SATURATE = 1
) (
    input  logic signed [IN_W-1:0]  val_i,
    output logic signed [OUT_W-1:0] val_o,
    output logic                    sat_o
);

    logic signed [IN_W-1:0] shifted;
    logic                   ovf;

    assign shifted = val_i >>> SHIFT;

    // The value fits only if every bit above the output sign bit copies it
    assign ovf = !((&shifted[IN_W-1:OUT_W-1]) || !(|shifted[IN_W-1:OUT_W-1]));

    always_comb begin
        val_o = {shifted[IN_W-1], shifted[OUT_W-2:0]};
        sat_o = 1'b0;
        if (WRAP_SATURATE != 0 && ovf) begin
            sat_o = 1'b1;
            val_o = shifted[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/comp_integrate_dump.sv
// Complex integrate-and-dump: sums windows of valid samples and emits one
// scaled, saturated complex result per window, one cycle after the last sample.
module comp_integrate_dump
    import comp_dsp_pkg::*;
#(
    parameter int INPUT_WIDTH   = 18,
    parameter int OUTPUT_WIDTH  = 18,
    parameter int MAX_LEN       = 1024,
    parameter int LEN_WIDTH     = 11,
    parameter int OUT_SHIFT     = 0,
    parameter int WRAP_SATURATE = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic signed [INPUT_WIDTH-1:0]  i_r,
    input  logic signed [INPUT_WIDTH-1:0]  i_im,
    input  logic                           i_valid_data,
    input  logic                           i_sync,
    input  logic        [LEN_WIDTH-1:0]    i_len,
    output logic signed [OUTPUT_WIDTH-1:0] o_acc_r,
    output logic signed [OUTPUT_WIDTH-1:0] o_acc_im,
    output logic                           o_valid_data,
    output logic                           o_sat,
    output logic                           o_busy
);

    localparam int ACC_W = acc_width(INPUT_WIDTH, MAX_LEN);

    state_e                         state_q;
    logic        [LEN_WIDTH-1:0]    len_q;
    logic        [LEN_WIDTH-1:0]    cnt_q;
    logic signed [ACC_W-1:0]        acc_r_q;
    logic signed [ACC_W-1:0]        acc_im_q;
    logic signed [OUTPUT_WIDTH-1:0] out_r_q;
    logic signed [OUTPUT_WIDTH-1:0] out_im_q;
    logic                           out_valid_q;
    logic                           out_sat_q;

    logic        [LEN_WIDTH-1:0]    len_sat;
    logic        [LEN_WIDTH-1:0]    eff_len;
    logic        [LEN_WIDTH-1:0]    cnt_d;
    logic signed [ACC_W-1:0]        sum_r;
    logic signed [ACC_W-1:0]        sum_im;
    logic                           run_active;
    logic                           take;
    logic                           dump;
    logic signed [OUTPUT_WIDTH-1:0] sat_val_r;
    logic signed [OUTPUT_WIDTH-1:0] sat_val_im;
    logic                           sat_r;
    logic                           sat_im;

    assign len_sat = (i_len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : i_len;

    // A sync restarts the window, so a sample arriving with it sees an empty window
    assign run_active = i_sync ? (i_len != '0) : (state_q == RUN);
    assign eff_len    = i_sync ? len_sat : len_q;
    assign cnt_d      = (i_sync ? '0 : cnt_q) + LEN_WIDTH'(1);
    assign sum_r      = (i_sync ? '0 : acc_r_q)
                      + {{(ACC_W-INPUT_WIDTH){i_r[INPUT_WIDTH-1]}}, i_r};
    assign sum_im     = (i_sync ? '0 : acc_im_q)
                      + {{(ACC_W-INPUT_WIDTH){i_im[INPUT_WIDTH-1]}}, i_im};
    assign take       = run_active && i_valid_data;
    assign dump       = take && (cnt_d == eff_len);

    sat_shift #(
        .IN_W          (ACC_W),
        .OUT_W         (OUTPUT_WIDTH),
        .SHIFT         (OUT_SHIFT),
        .WRAP_SATURATE (WRAP_SATURATE)
    ) u_sat_r (
        .val_i (sum_r),
        .val_o (sat_val_r),
        .sat_o (sat_r)
    );

    sat_shift #(
        .IN_W          (ACC_W),
        .OUT_W         (OUTPUT_WIDTH),
        .SHIFT         (OUT_SHIFT),
        .WRAP_SATURATE (WRAP_SATURATE)
    ) u_sat_im (
        .val_i (sum_im),
        .val_o (sat_val_im),
        .sat_o (sat_im)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_r_q     <= '0;
            acc_im_q    <= '0;
            out_r_q     <= '0;
            out_im_q    <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (i_sync) begin
                state_q <= (i_len != '0) ? RUN : IDLE;
                len_q   <= len_sat;
            end
            if (dump) begin
                acc_r_q     <= '0;
                acc_im_q    <= '0;
                cnt_q       <= '0;
                out_r_q     <= sat_val_r;
                out_im_q    <= sat_val_im;
                out_sat_q   <= sat_r || sat_im;
                out_valid_q <= 1'b1;
            end else if (take) begin
                acc_r_q  <= sum_r;
                acc_im_q <= sum_im;
                cnt_q    <= cnt_d;
            end else if (i_sync) begin
                acc_r_q  <= '0;
                acc_im_q <= '0;
                cnt_q    <= '0;
            end
        end
    end

    assign o_acc_r      = out_r_q;
    assign o_acc_im     = out_im_q;
    assign o_valid_data = out_valid_q;
    assign o_sat        = out_sat_q;
    assign o_busy       = (state_q == RUN);

endmodule

// File: tb/tb_comp_integrate_dump.sv
// Directed bench for comp_integrate_dump: a vector table for the single-window
// scenarios plus hand sequences for saturation, clamping and mid-window reset.
module tb_comp_integrate_dump;

    logic               clk;
    logic               rst_n;
    logic signed [17:0] rIn;
    logic signed [17:0] imIn;
    logic               vld;
    logic               sync;
    logic [10:0]        len;

    logic signed [17:0] accR0, accIm0, accR3, accIm3, accRw, accImw;
    logic               vld0, sat0, busy0;
    logic               vld3, sat3, busy3;
    logic               vldw, satw, busyw;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sync;
        logic [10:0] len;
        logic        vld;
        int          r;
        int          im;
        logic        expV;
        int          expR;
        int          expIm;
        logic        expSat;
        logic        expBusy;
    } vec_t;

    vec_t vecs[$];

    comp_integrate_dump #(.OUT_SHIFT(0), .WRAP_SATURATE(1)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_r(rIn), .i_im(imIn),
        .i_valid_data(vld), .i_sync(sync), .i_len(len),
        .o_acc_r(accR0), .o_acc_im(accIm0), .o_valid_data(vld0),
        .o_sat(sat0), .o_busy(busy0)
    );

    comp_integrate_dump #(.OUT_SHIFT(3), .WRAP_SATURATE(1)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_r(rIn), .i_im(imIn),
        .i_valid_data(vld), .i_sync(sync), .i_len(len),
        .o_acc_r(accR3), .o_acc_im(accIm3), .o_valid_data(vld3),
        .o_sat(sat3), .o_busy(busy3)
    );

    comp_integrate_dump #(.OUT_SHIFT(0), .WRAP_SATURATE(0)) dutw (
        .i_clk(clk), .i_rst_n(rst_n), .i_r(rIn), .i_im(imIn),
        .i_valid_data(vld), .i_sync(sync), .i_len(len),
        .o_acc_r(accRw), .o_acc_im(accImw), .o_valid_data(vldw),
        .o_sat(satw), .o_busy(busyw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic addVec(input logic s, input int l, input logic v, input int r, input int im,
                          input logic eV, input int eR, input int eIm, input logic eS, input logic eB);
        vec_t t;
        t.sync = s; t.len = 11'(l); t.vld = v; t.r = r; t.im = im;
        t.expV = eV; t.expR = eR; t.expIm = eIm; t.expSat = eS; t.expBusy = eB;
        vecs.push_back(t);
    endtask

    // Drive one cycle of inputs at the falling edge, then let the rising edge sample them
    task automatic applyStimulus(input logic s, input int l, input logic v, input int r, input int im);
        @(negedge clk);
        sync = s; len = 11'(l); vld = v; rIn = 18'(r); imIn = 18'(im);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; sync = 1'b0; len = '0; vld = 1'b0; rIn = '0; imIn = '0;

        // len=4 back to back
        addVec(1, 4, 1, 1, -1,    0, 0, 0, 0, 1);
        addVec(0, 0, 1, 2, -2,    0, 0, 0, 0, 1);
        addVec(0, 0, 1, 3, -3,    0, 0, 0, 0, 1);
        addVec(0, 0, 1, 4, -4,    1, 10, -10, 0, 1);
        addVec(0, 0, 0, 99, 99,   0, 10, -10, 0, 1);
        // Same window with two-cycle gaps carrying junk data
        addVec(1, 4, 1, 1, -1,    0, 10, -10, 0, 1);
        addVec(0, 0, 0, 99, 99,   0, 10, -10, 0, 1);
        addVec(0, 0, 0, 99, 99,   0, 10, -10, 0, 1);
        addVec(0, 0, 1, 2, -2,    0, 10, -10, 0, 1);
        addVec(0, 0, 0, 99, 99,   0, 10, -10, 0, 1);
        addVec(0, 0, 0, 99, 99,   0, 10, -10, 0, 1);
        addVec(0, 0, 1, 3, -3,    0, 10, -10, 0, 1);
        addVec(0, 0, 0, 99, 99,   0, 10, -10, 0, 1);
        addVec(0, 0, 0, 99, 99,   0, 10, -10, 0, 1);
        addVec(0, 0, 1, 4, -4,    1, 10, -10, 0, 1);
        addVec(0, 0, 0, 99, 99,   0, 10, -10, 0, 1);
        // Restart mid-window: partial (5,5)+(5,5) discarded
        addVec(1, 4, 1, 5, 5,     0, 10, -10, 0, 1);
        addVec(0, 0, 1, 5, 5,     0, 10, -10, 0, 1);
        addVec(1, 4, 1, 1, 0,     0, 10, -10, 0, 1);
        addVec(0, 0, 1, 1, 0,     0, 10, -10, 0, 1);
        addVec(0, 0, 1, 1, 0,     0, 10, -10, 0, 1);
        addVec(0, 0, 1, 1, 0,     1, 4, 0, 0, 1);
        addVec(0, 0, 0, 99, 99,   0, 4, 0, 0, 1);
        // len=1 ramp, then len=0 sync drops to IDLE
        addVec(1, 1, 1, 0, 0,     1, 0, 0, 0, 1);
        addVec(0, 0, 1, 1, 0,     1, 1, 0, 0, 1);
        addVec(0, 0, 1, 2, 0,     1, 2, 0, 0, 1);
        addVec(0, 0, 1, 3, 0,     1, 3, 0, 0, 1);
        addVec(1, 0, 1, 9, 0,     0, 3, 0, 0, 0);
        addVec(0, 0, 1, 5, 0,     0, 3, 0, 0, 0);
        addVec(1, 0, 1, 7, 0,     0, 3, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset accR", int'(accR0), 0);
        checkOutput("reset accIm", int'(accIm0), 0);
        checkOutput("reset valid", int'(vld0), 0);
        checkOutput("reset sat", int'(sat0), 0);
        checkOutput("reset busy", int'(busy0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sync, int'(vecs[i].len), vecs[i].vld, vecs[i].r, vecs[i].im);
            checkOutput($sformatf("vec%0d valid", i), int'(vld0), int'(vecs[i].expV));
            checkOutput($sformatf("vec%0d accR", i), int'(accR0), vecs[i].expR);
            checkOutput($sformatf("vec%0d accIm", i), int'(accIm0), vecs[i].expIm);
            checkOutput($sformatf("vec%0d sat", i), int'(sat0), int'(vecs[i].expSat));
            checkOutput($sformatf("vec%0d busy", i), int'(busy0), int'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d wrapR", i), int'(accRw), vecs[i].expR);
            checkOutput($sformatf("vec%0d wrapIm", i), int'(accImw), vecs[i].expIm);
        end

        // Oversized length clamps to 1024 samples
        begin
            int early;
            early = 0;
            applyStimulus(1, 2000, 1, 1, -1);
            if (vld0) early++;
            for (int k = 1; k < 1023; k++) begin
                applyStimulus(0, 0, 1, 1, -1);
                if (vld0) early++;
            end
            checkOutput("clamp early pulses", early, 0);
            applyStimulus(0, 0, 1, 1, -1);
            checkOutput("clamp valid", int'(vld0), 1);
            checkOutput("clamp accR", int'(accR0), 1024);
            checkOutput("clamp accIm", int'(accIm0), -1024);
        end

        // Extreme samples: saturate unshifted, exact with shift 3, wrap keeps low bits
        applyStimulus(1, 8, 1, 131071, -131072);
        for (int k = 1; k < 8; k++) applyStimulus(0, 0, 1, 131071, -131072);
        checkOutput("sat0 valid", int'(vld0), 1);
        checkOutput("sat0 accR", int'(accR0), 131071);
        checkOutput("sat0 accIm", int'(accIm0), -131072);
        checkOutput("sat0 flag", int'(sat0), 1);
        checkOutput("shift3 valid", int'(vld3), 1);
        checkOutput("shift3 accR", int'(accR3), 131071);
        checkOutput("shift3 accIm", int'(accIm3), -131072);
        checkOutput("shift3 flag", int'(sat3), 0);
        checkOutput("wrap accR", int'(accRw), 131064);
        checkOutput("wrap accIm", int'(accImw), -131072);
        checkOutput("wrap flag", int'(satw), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("sat0 hold flag", int'(sat0), 1);

        // Mid-window reset clears outputs at once and leaves the block idle
        applyStimulus(1, 4, 1, 1, 1);
        applyStimulus(0, 0, 1, 1, 1);
        applyStimulus(0, 0, 1, 1, 1);
        @(negedge clk);
        vld = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst accR", int'(accR0), 0);
        checkOutput("rst accIm", int'(accIm0), 0);
        checkOutput("rst sat", int'(sat0), 0);
        checkOutput("rst busy", int'(busy0), 0);
        #2;
        rst_n = 1'b1;
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("post-rst valid", int'(vld0), 0);
        checkOutput("post-rst busy", int'(busy0), 0);
        checkOutput("post-rst accR", int'(accR0), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("post-rst valid2", int'(vld0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
